// File: rtl/piso_frame_sequencer_if.sv
// Bundle between the frame-buffer read logic and the PISO frame sequencer.
// slave: the sequencer itself; master: the upstream/driver-side view.
interface piso_frame_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             buf_sel;
  logic [CNT_W-1:0] num_words;
  logic             load_a;
  logic             load_b;
  logic             shift;
  logic             sclk;
  logic             latch;
  logic [CNT_W-1:0] word_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, buf_sel, num_words,
    input  load_a, load_b, shift, sclk, latch, word_idx, busy, done
  );

  modport slave (
    input  start, abort, buf_sel, num_words,
    output load_a, load_b, shift, sclk, latch, word_idx, busy, done
  );
endinterface

// File: rtl/piso_frame_sequencer.sv
// Streams num_words words through one PISO register: load, WIDTH shifts at DIV clk/bit, latch, done.
// Outputs are registered (one cycle after the state decision); start is ignored while not IDLE.
module piso_frame_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int LATCH_LEN = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  piso_frame_sequencer_if.slave bus
);
  localparam int DW  = $clog2(DIV) + 1;
  localparam int BW  = $clog2(WIDTH) + 1;
  localparam int LW  = $clog2(LATCH_LEN) + 1;
  localparam int CW1 = CNT_W + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

  state_t           state;
  logic             sel;
  logic [CNT_W-1:0] nw;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [LW-1:0]    lat_cnt;

  logic [DW-1:0] div_nxt;
  logic [CNT_W:0] idx_inc;
  logic           more;

  assign div_nxt = div_cnt + DW'(1);
  assign idx_inc = {1'b0, bus.word_idx} + CW1'(1);
  assign more    = idx_inc < {1'b0, nw};

  // Output registers are set for the cycle that follows each transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sel          <= 1'b0;
      nw           <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      lat_cnt      <= '0;
      bus.load_a   <= 1'b0;
      bus.load_b   <= 1'b0;
      bus.shift    <= 1'b0;
      bus.sclk     <= 1'b0;
      bus.latch    <= 1'b0;
      bus.word_idx <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.load_a <= 1'b0;
      bus.load_b <= 1'b0;
      bus.shift  <= 1'b0;
      bus.sclk   <= 1'b0;
      bus.latch  <= 1'b0;
      bus.done   <= 1'b0;
      if (bus.abort) begin
        state    <= IDLE;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        lat_cnt  <= '0;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.busy <= 1'b0;
            if (bus.start) begin
              if (bus.num_words != '0) begin
                state        <= LOAD;
                sel          <= bus.buf_sel;
                nw           <= bus.num_words;
                bus.word_idx <= '0;
                bus.load_a   <= ~bus.buf_sel;
                bus.load_b   <= bus.buf_sel;
                bus.busy     <= 1'b1;
              end else begin
                state    <= DONE;
                bus.done <= 1'b1;
              end
            end
          end
          LOAD: begin
            state   <= SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
          SHIFT: begin
            if (div_cnt != DIV_LAST) begin
              div_cnt   <= div_nxt;
              bus.sclk  <= (div_nxt >= DIV_HALF);
              bus.shift <= (div_nxt == DIV_LAST);
            end else begin
              div_cnt <= '0;
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BIT_LAST) begin
                if (more) begin
                  state        <= LOAD;
                  bus.word_idx <= idx_inc[CNT_W-1:0];
                  bus.load_a   <= ~sel;
                  bus.load_b   <= sel;
                end else begin
                  state     <= LATCH;
                  lat_cnt   <= '0;
                  bus.latch <= 1'b1;
                end
              end
            end
          end
          LATCH: begin
            if (lat_cnt == LAT_LAST) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              lat_cnt   <= lat_cnt + LW'(1);
              bus.latch <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/piso_frame_sequencer.md
Name: piso_frame_sequencer

Overview:
Controller that sequences one WIDTH-bit parallel-in/serial-out shift register to stream a frame of num_words words to LED driver chips. It drives the register's load_a/load_b and shift strobes, and generates the serial clock and latch pulse for the drivers. It also presents a word index to the upstream frame buffer and reports busy and done. It sits between the frame-buffer read logic and the shift register.

Parameters:
WIDTH, 8, bits per word; number of shift pulses per load.
DIV, 4, clk cycles per serial bit; must be even and at least 2.
LATCH_LEN, 2, clk cycles that latch is held high after the last word.
CNT_W, 8, width of num_words and word_idx.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset; asynchronous, active-low.
start  in  1  frame request; sampled only in IDLE.
abort  in  1  synchronous cancel; effective in any state.
buf_sel  in  1  source select, sampled with start: 0 = load_a, 1 = load_b.
num_words  in  CNT_W  words in the frame, sampled with start.
load_a  out  1  load strobe for parallel input a.
load_b  out  1  load strobe for parallel input b.
shift  out  1  shift strobe to the register.
sclk  out  1  serial clock to the driver chips.
latch  out  1  driver latch pulse.
word_idx  out  CNT_W  index of the word being loaded; upstream must present data for it.
busy  out  1  frame in progress.
done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs and counters 0.
- Outputs must be glitch-free: registered, or decoded from registered state only.
- States: IDLE, LOAD, SHIFT, LATCH, DONE.
- IDLE: if start=1 and num_words!=0, latch buf_sel and num_words, clear word_idx, go to LOAD.
  - If start=1 and num_words==0, go straight to DONE. No load, shift or latch occurs.
- LOAD (1 cycle): exactly one of load_a/load_b high, per the latched buf_sel. word_idx is valid. Next state SHIFT with bit_cnt=0 and div_cnt=0.
- SHIFT: div_cnt counts 0..DIV-1 per bit.
  - sclk=1 while div_cnt>=DIV/2.
  - shift=1 when div_cnt==DIV-1; bit_cnt increments on the same cycle.
  - After the WIDTH-th shift:
    - if word_idx+1 < latched num_words: word_idx increments and the state goes to LOAD;
    - otherwise the state goes to LATCH.
  - The last-bit shift is always issued.
- LATCH: latch=1 for LATCH_LEN cycles, then DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in LOAD, SHIFT and LATCH; busy=0 in IDLE and DONE.
- load_a, load_b, shift and latch are mutually exclusive. sclk=0 outside SHIFT.
- start is ignored outside IDLE, including the DONE cycle.
- Frame length in cycles, start-sample cycle through done inclusive: 1 + N*(1+WIDTH*DIV) + LATCH_LEN + 1.
- abort=1 in any state: next state IDLE. All strobes, sclk, latch and busy are 0 the following cycle. No done, no latch. Counters clear.
  - abort together with start in IDLE: abort wins and the start is dropped.
- reset_n low mid-frame: immediate return to reset values.
- word_idx holds its last value in IDLE and is cleared on accepting start.

Test Plan:
(All scenarios: WIDTH=8, DIV=4, LATCH_LEN=2; cycle 0 is the cycle in which start is sampled.)
1. Reset asserted mid-SHIFT -> all outputs 0 immediately; after release, state IDLE and busy=0.
2. start, buf_sel=0, num_words=1 -> load_a at cycle 1 with word_idx=0; shift at cycles 5,9,...,33 (8 pulses); sclk high at cycles 4-5, 8-9, ..., 32-33; latch at cycles 34-35; done at 36; load_b never asserted.
3. start, buf_sel=1, num_words=3 -> load_b at cycles 1, 34, 67 with word_idx 0, 1, 2; 24 shifts total; latch at 100-101; done at 102; busy high for cycles 1-101.
4. start pulsed at cycles 10 and 36 during a frame from scenario 2 -> both ignored; start at cycle 37 accepted, load_a at cycle 38.
5. abort at cycle 15 of scenario 2 -> from cycle 16, busy/sclk/shift=0; no latch, no done; a following start runs a full normal frame.
6. start with num_words=0 -> done at cycle 1; no load, shift, sclk or latch; busy stays 0.
